watch_mode_ctrl: RTL

WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

---
 rtl/watch_mode_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/watch_mode_ctrl.sv
// Six-button mode/set controller for a multi-mode watch display.
// Buttons are synchronized, debounced and edge-detected, then drive a BROWSE/SET FSM and blink generator.
module watch_mode_ctrl #(
   parameter int DEB_CYCLES = 20000,
   parameter int BLINK_DIV  = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       up_i,
   input  logic       down_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       enter_i,
   input  logic       esc_i,
   output logic [2:0] mode,
   output logic       setting,
   output logic [1:0] field,
   output logic [5:0] blink_mask,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       commit_pulse,
   output logic       cancel_pulse
);

   localparam int NBTN    = 6;
   localparam int B_RIGHT = 0;
   localparam int B_LEFT  = 1;
   localparam int B_DOWN  = 2;
   localparam int B_UP    = 3;
   localparam int B_ENTER = 4;
   localparam int B_ESC   = 5;

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_DIV - 1);

   localparam logic [2:0] MODE_LAST  = 3'd6;
   localparam logic [2:0] MODE_RESET = 3'd1;
   localparam logic [1:0] FIELD_LAST = 2'd2;

   typedef enum logic {ST_BROWSE, ST_SET} state_t;
   typedef enum logic [2:0] {
      ACT_NONE, ACT_ESC, ACT_ENTER, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT
   } act_t;

   // ---------------- button front end ----------------
   logic [NBTN-1:0] raw_btn;
   logic [NBTN-1:0] sync1, sync2;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] deb_level, deb_prev, armed;
   logic [DW-1:0]   deb_cnt [NBTN];
   logic [NBTN-1:0] press;

   assign raw_btn   = {esc_i, enter_i, up_i, down_i, left_i, right_i};
   assign btn_level = ~sync2;
   assign press     = armed & deb_level & ~deb_prev;

   // NOTE: synchronizers reset to the "pressed" level so that a button held through
   // reset looks pressed from the start and can only arm after a genuine release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         deb_level <= '0;
         deb_prev  <= '0;
         armed     <= '0;
         for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
      end else begin
         sync1    <= raw_btn;
         sync2    <= sync1;
         deb_prev <= deb_level;
         for (int i = 0; i < NBTN; i++) begin
            if (btn_level[i] != deb_level[i]) begin
               if (deb_cnt[i] == DEB_MAX) begin
                  deb_cnt[i]   <= '0;
                  deb_level[i] <= btn_level[i];
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
            if (!btn_level[i] && !deb_level[i]) armed[i] <= 1'b1;
         end
      end
   end

   // ---------------- event arbitration ----------------
   act_t act;

   always_comb begin
      act = ACT_NONE;
      if      (press[B_ESC])   act = ACT_ESC;
      else if (press[B_ENTER]) act = ACT_ENTER;
      else if (press[B_UP])    act = ACT_UP;
      else if (press[B_DOWN])  act = ACT_DOWN;
      else if (press[B_LEFT])  act = ACT_LEFT;
      else if (press[B_RIGHT]) act = ACT_RIGHT;
   end

   // ---------------- mode FSM ----------------
   state_t     state, state_n;
   logic [2:0] mode_n;
   logic [1:0] field_n;
   logic       inc_n, dec_n, commit_n, cancel_n;
   logic       blink_restart;

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_n       = state;
      mode_n        = mode;
      field_n       = field;
      inc_n         = 1'b0;
      dec_n         = 1'b0;
      commit_n      = 1'b0;
      cancel_n      = 1'b0;
      blink_restart = 1'b0;
      unique case (state)
         ST_BROWSE: begin
            unique case (act)
               ACT_UP:    mode_n = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;
               ACT_DOWN:  mode_n = (mode == 3'd0) ? MODE_LAST : mode - 3'd1;
               ACT_ENTER: begin
                  if (mode <= 3'd2) begin
                     state_n       = ST_SET;
                     field_n       = FIELD_LAST;
                     blink_restart = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         ST_SET: begin
            unique case (act)
               ACT_ESC: begin
                  state_n  = ST_BROWSE;
                  cancel_n = 1'b1;
               end
               ACT_ENTER: begin
                  state_n  = ST_BROWSE;
                  commit_n = 1'b1;
               end
               ACT_UP:   inc_n = 1'b1;
               ACT_DOWN: dec_n = 1'b1;
               ACT_LEFT: begin
                  field_n       = (field == FIELD_LAST) ? 2'd0 : field + 2'd1;
                  blink_restart = 1'b1;
               end
               ACT_RIGHT: begin
                  field_n       = (field == 2'd0) ? FIELD_LAST : field - 2'd1;
                  blink_restart = 1'b1;
               end
               default: ;
            endcase
         end
         default: state_n = ST_BROWSE;
      endcase
   end

   // ---------------- blink generator ----------------
   logic [CW-1:0] blink_cnt, blink_cnt_n;
   logic          phase, phase_n;
   logic [5:0]    mask_n;

   always_comb begin
      blink_cnt_n = blink_cnt;
      phase_n     = phase;
      if (blink_restart) begin
         blink_cnt_n = '0;
         phase_n     = 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt_n = '0;
         phase_n     = ~phase;
      end else begin
         blink_cnt_n = blink_cnt + 1'b1;
      end

      // Mask is built from next-state values so it lines up with the registered field/phase.
      mask_n = 6'b111111;
      if (state_n == ST_SET) begin
         unique case (field_n)
            2'd0:    mask_n[1:0] = {2{phase_n}};
            2'd1:    mask_n[3:2] = {2{phase_n}};
            default: mask_n[5:4] = {2{phase_n}};
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_BROWSE;
         mode         <= MODE_RESET;
         field        <= FIELD_LAST;
         setting      <= 1'b0;
         blink_mask   <= 6'b111111;
         inc_pulse    <= 1'b0;
         dec_pulse    <= 1'b0;
         commit_pulse <= 1'b0;
         cancel_pulse <= 1'b0;
         blink_cnt    <= '0;
         phase        <= 1'b1;
      end else begin
         state        <= state_n;
         mode         <= mode_n;
         field        <= field_n;
         setting      <= (state_n == ST_SET);
         blink_mask   <= mask_n;
         inc_pulse    <= inc_n;
         dec_pulse    <= dec_n;
         commit_pulse <= commit_n;
         cancel_pulse <= cancel_n;
         blink_cnt    <= blink_cnt_n;
         phase        <= phase_n;
      end
   end

endmodule
